// File: rtl/trace_buffer_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : trace_pkg                                              |
// | Description : Shared event/source codes, payload field offsets and   |
// |               capture state encoding for the multi-channel trace     |
// |               buffer.                                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package trace_pkg;

    // Event type codes (payload bits [47:40])
    localparam logic [7:0] c_ev_idle       = 8'h00;
    localparam logic [7:0] c_ev_fdc_cmd    = 8'h01;
    localparam logic [7:0] c_ev_fdc_done   = 8'h02;
    localparam logic [7:0] c_ev_hdd_cmd    = 8'h03;
    localparam logic [7:0] c_ev_hdd_done   = 8'h04;
    localparam logic [7:0] c_ev_usb_xfer   = 8'h05;
    localparam logic [7:0] c_ev_usb_err    = 8'h06;
    localparam logic [7:0] c_ev_pll_lock   = 8'h07;
    localparam logic [7:0] c_ev_pll_unlock = 8'h08;
    localparam logic [7:0] c_ev_irq        = 8'h09;
    localparam logic [7:0] c_ev_dma        = 8'h0A;
    localparam logic [7:0] c_ev_timeout    = 8'h0B;
    localparam logic [7:0] c_ev_reset      = 8'h0C;
    localparam logic [7:0] c_ev_user       = 8'h0D;
    localparam logic [7:0] c_ev_marker     = 8'h0E;
    localparam logic [7:0] c_ev_trig_hit   = 8'h0F;

    // Source codes (payload bits [39:32])
    localparam logic [7:0] c_src_system = 8'h00;
    localparam logic [7:0] c_src_fdc    = 8'h01;
    localparam logic [7:0] c_src_hdd    = 8'h02;
    localparam logic [7:0] c_src_usb    = 8'h03;
    localparam logic [7:0] c_src_pll    = 8'h04;
    localparam logic [7:0] c_src_cpu    = 8'h05;
    localparam logic [7:0] c_src_dma    = 8'h06;
    localparam logic [7:0] c_src_irq    = 8'h07;
    localparam logic [7:0] c_src_timer  = 8'h08;
    localparam logic [7:0] c_src_debug  = 8'h09;

    // Payload field offsets
    localparam int c_type_lsb = 40;
    localparam int c_src_lsb  = 32;
    localparam int c_data_lsb = 0;
    localparam int c_field_w  = 8;
    localparam int c_data_w   = 32;

    // Capture state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_POST = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/trace_buffer_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : trace_buffer_mc_if                                     |
// | Description : Channel valid/ready bus and readout bus of the trace   |
// |               buffer. master = sources/console, slave = buffer.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface trace_buffer_mc_if #(
    parameter int NCH        = 4,
    parameter int DEPTH_LOG2 = 12,
    parameter int TS_W       = 16,
    parameter int PAYLOAD_W  = 48
);
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ENTRY_W = TS_W + CH_W + PAYLOAD_W;

    logic [NCH-1:0]           ch_valid;
    logic [NCH*PAYLOAD_W-1:0] ch_data;
    logic [NCH-1:0]           ch_ready;
    logic                     rd_en;
    logic [DEPTH_LOG2-1:0]    rd_addr;
    logic [ENTRY_W-1:0]       rd_data;
    logic                     rd_valid;

    modport master (
        output ch_valid, ch_data, rd_en, rd_addr,
        input  ch_ready, rd_data, rd_valid
    );

    modport slave (
        input  ch_valid, ch_data, rd_en, rd_addr,
        output ch_ready, rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/trace_buffer_mc_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : trace_rr_arb                                           |
// | Description : NCH-way round-robin arbiter. Search starts one past    |
// |               the last granted channel; grant is combinational.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module trace_rr_arb #(
    parameter int NCH  = 4,
    parameter int CH_W = 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [NCH-1:0]  req,
    output logic [NCH-1:0]  grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_vld
);
    logic [CH_W-1:0] r_ptr;
    logic [CH_W:0]   w_cand;

    // Pick the first requester at or after the pointer, wrapping at NCH
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            w_cand = {1'b0, r_ptr} + (CH_W+1)'(k);
            if (w_cand >= (CH_W+1)'(NCH))
                w_cand = w_cand - (CH_W+1)'(NCH);
            if (en && !grant_vld && req[w_cand[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = w_cand[CH_W-1:0];
            end
        end
        if (grant_vld)
            grant[grant_idx] = 1'b1;
    end

    // Pointer moves to one past the channel that just transferred
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_ptr <= '0;
        else if (grant_vld)
            r_ptr <= (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
endmodule
`default_nettype wire

// File: rtl/trace_buffer_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : trace_buffer_mc                                        |
// | Description : Multi-channel circular trace buffer with round-robin   |
// |               source arbitration, pre/post trigger capture FSM and  |
// |               oldest-relative readout.                               |
// | Options     : TRACE_DATA_MATCH_EN adds a masked data compare to the |
// |               event-match trigger.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module trace_buffer_mc
    import trace_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DEPTH_LOG2 = 12,
    parameter int TS_W       = 16,
    parameter int PAYLOAD_W  = 48
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [DEPTH_LOG2-1:0] post_cnt,
    input  logic                  trig_in,
    input  logic                  trig_match_en,
    input  logic [7:0]            trig_type_mask,
    input  logic [7:0]            trig_src_mask,
`ifdef TRACE_DATA_MATCH_EN
    input  logic [31:0]           trig_data_val,
    input  logic [31:0]           trig_data_mask,
`endif
    trace_buffer_mc_if.slave      bus,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2-1:0] trigger_pos,
    output logic                  wrapped,
    output logic                  triggered
);
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ENTRY_W = TS_W + CH_W + PAYLOAD_W;
    localparam int c_depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_count_max = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [1:0]            r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_trig_abs, r_post_cnt, r_post_wr, w_post_wr_nxt;
    logic [DEPTH_LOG2-1:0] w_oldest, w_rd_idx;
    logic [TS_W-1:0]       r_ts;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_wrapped, r_triggered, r_trig_pend;
    logic [ENTRY_W-1:0]    r_mem [c_depth];
    logic [ENTRY_W-1:0]    r_rd_data;
    logic                  r_rd_valid;

    logic                  w_capturing, w_arb_en, w_xfer, w_data_ok, w_match;
    logic                  w_trig_acc, w_trig_entry, w_post_entry, w_post_reached;
    logic [NCH-1:0]        w_grant;
    logic [CH_W-1:0]       w_grant_idx;
    logic [PAYLOAD_W-1:0]  w_payload;

    trace_rr_arb #(.NCH(NCH), .CH_W(CH_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .clr       (arm),
        .en        (w_arb_en),
        .req       (bus.ch_valid),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_vld (w_xfer)
    );

    assign bus.ch_ready = w_grant;
    assign w_payload    = bus.ch_data[w_grant_idx * PAYLOAD_W +: PAYLOAD_W];

`ifdef TRACE_DATA_MATCH_EN
    assign w_data_ok = (((w_payload[c_data_lsb +: c_data_w] ^ trig_data_val) & trig_data_mask) == '0);
`else
    assign w_data_ok = 1'b1;
`endif

    assign w_match = trig_match_en && w_xfer && w_data_ok
                   && (|(w_payload[c_type_lsb +: c_field_w] & trig_type_mask))
                   && (|(w_payload[c_src_lsb  +: c_field_w] & trig_src_mask));

    // Trigger bookkeeping: the trigger entry is this cycle's transfer or, if
    // none, the next one written while in POST with a trigger pending
    always_comb begin
        w_trig_acc    = (r_state == ST_PRE) && !arm && !stop && (trig_in || w_match);
        w_trig_entry  = w_xfer && (w_trig_acc || ((r_state == ST_POST) && r_trig_pend));
        w_post_entry  = w_xfer && (r_state == ST_POST) && !r_trig_pend;
        w_post_wr_nxt = r_post_wr;
        if (w_post_entry && (r_post_wr != r_post_cnt))
            w_post_wr_nxt = r_post_wr + DEPTH_LOG2'(1);
        if (r_state == ST_PRE)
            w_post_reached = w_trig_entry && (post_cnt == '0);
        else
            w_post_reached = (!r_trig_pend || w_xfer) && (w_post_wr_nxt == r_post_cnt);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; arm overrides everything, including stop
    always_comb begin
        w_state_nxt = r_state;
        if (arm)
            w_state_nxt = ST_PRE;
        else begin
            case (r_state)
                ST_PRE: begin
                    if (stop)
                        w_state_nxt = ST_DONE;
                    else if (w_trig_acc)
                        w_state_nxt = (w_post_reached && !continuous) ? ST_DONE : ST_POST;
                end
                ST_POST: begin
                    if (stop || (w_post_reached && !continuous))
                        w_state_nxt = ST_DONE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // FSM outputs: grants only while capturing and never in the arm cycle
    always_comb begin
        w_capturing = (r_state == ST_PRE) || (r_state == ST_POST);
        w_arb_en    = w_capturing && !arm;
        state       = r_state;
    end

    // Capture datapath: pointers, occupancy, timestamp and trigger tracking.
    // post_cnt is DEPTH_LOG2 bits wide, so it can never exceed DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            r_wr_ptr    <= '0;
            r_ts        <= '0;
            r_count     <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
            r_trig_pend <= 1'b0;
            r_trig_abs  <= '0;
            r_post_cnt  <= '0;
            r_post_wr   <= '0;
        end else begin
            if (w_capturing)
                r_ts <= r_ts + TS_W'(1);
            if (w_xfer) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
                if (r_count != c_count_max)
                    r_count <= r_count + (DEPTH_LOG2+1)'(1);
                if (&r_wr_ptr)
                    r_wrapped <= 1'b1;
            end
            if (w_trig_acc) begin
                r_triggered <= 1'b1;
                r_post_cnt  <= post_cnt;
                r_trig_pend <= !w_xfer;
            end
            if (w_trig_entry) begin
                r_trig_abs  <= r_wr_ptr;
                r_trig_pend <= 1'b0;
            end
            r_post_wr <= w_post_wr_nxt;
        end
    end

    // Buffer write port (no reset so it maps onto block RAM)
    always_ff @(posedge clk) begin
        if (w_xfer)
            r_mem[r_wr_ptr] <= {r_ts, w_grant_idx, w_payload};
    end

    assign w_oldest = r_wrapped ? r_wr_ptr : '0;
    assign w_rd_idx = w_oldest + bus.rd_addr;

    // Registered read port addressed relative to the oldest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en)
                r_rd_data <= r_mem[w_rd_idx];
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign count        = r_count;
    assign trigger_pos  = r_trig_abs - w_oldest;
    assign wrapped      = r_wrapped;
    assign triggered    = r_triggered;
endmodule
`default_nettype wire

// File: tb/tb_trace_buffer_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_trace_buffer_mc                                     |
// | Description : Directed bench for trace_buffer_mc: round-robin table, |
// |               trigger/post-count, match trigger, continuous, reset.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_trace_buffer_mc;
    import trace_pkg::*;

    localparam int NCH        = 4;
    localparam int DEPTH_LOG2 = 4;
    localparam int TS_W       = 16;
    localparam int PAYLOAD_W  = 48;
    localparam int CH_W       = 2;
    localparam int ENTRY_W    = TS_W + CH_W + PAYLOAD_W;

    logic                  clk = 1'b0;
    logic                  rst, arm, stop, continuous, trig_in, trig_match_en;
    logic [DEPTH_LOG2-1:0] post_cnt;
    logic [7:0]            trig_type_mask, trig_src_mask;
    logic [1:0]            state;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2-1:0] trigger_pos;
    logic                  wrapped, triggered;
`ifdef TRACE_DATA_MATCH_EN
    logic [31:0]           trig_data_val  = '0;
    logic [31:0]           trig_data_mask = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    trace_buffer_mc_if #(.NCH(NCH), .DEPTH_LOG2(DEPTH_LOG2), .TS_W(TS_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    trace_buffer_mc #(.NCH(NCH), .DEPTH_LOG2(DEPTH_LOG2), .TS_W(TS_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .stop           (stop),
        .continuous     (continuous),
        .post_cnt       (post_cnt),
        .trig_in        (trig_in),
        .trig_match_en  (trig_match_en),
        .trig_type_mask (trig_type_mask),
        .trig_src_mask  (trig_src_mask),
`ifdef TRACE_DATA_MATCH_EN
        .trig_data_val  (trig_data_val),
        .trig_data_mask (trig_data_mask),
`endif
        .bus            (bus),
        .state          (state),
        .count          (count),
        .trigger_pos    (trigger_pos),
        .wrapped        (wrapped),
        .triggered      (triggered)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0]      valid;
        logic [NCH-1:0]      ready;
        logic [DEPTH_LOG2:0] cnt;
    } vec_t;

    vec_t                 tbl [14];
    logic [ENTRY_W-1:0]   exp_q [$];

    function automatic logic [PAYLOAD_W-1:0] pl(input logic [7:0] t, input logic [7:0] s, input logic [31:0] d);
        return {t, s, d};
    endfunction

    function automatic logic [ENTRY_W-1:0] ent(input logic [TS_W-1:0] ts, input logic [CH_W-1:0] ch,
                                               input logic [PAYLOAD_W-1:0] p);
        return {ts, ch, p};
    endfunction

    function automatic logic [CH_W-1:0] oh2idx(input logic [NCH-1:0] oh);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++)
            if (oh[i]) r = CH_W'(i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_all(input logic [7:0] t, input logic [31:0] d);
        for (int c = 0; c < NCH; c++)
            bus.ch_data[c*PAYLOAD_W +: PAYLOAD_W] = pl(t, 8'(c), d);
    endtask

    task automatic do_arm();
        @(negedge clk);
        arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [DEPTH_LOG2-1:0] a, input logic [ENTRY_W-1:0] exp);
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, ENTRY_W'(bus.rd_valid), ENTRY_W'(1));
        chk(nm, bus.rd_data, exp);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001, 5'd1};
        tbl[1]  = '{4'b1111, 4'b0010, 5'd2};
        tbl[2]  = '{4'b1111, 4'b0100, 5'd3};
        tbl[3]  = '{4'b1111, 4'b1000, 5'd4};
        tbl[4]  = '{4'b1111, 4'b0001, 5'd5};
        tbl[5]  = '{4'b1111, 4'b0010, 5'd6};
        tbl[6]  = '{4'b1111, 4'b0100, 5'd7};
        tbl[7]  = '{4'b1111, 4'b1000, 5'd8};
        tbl[8]  = '{4'b0000, 4'b0000, 5'd8};
        tbl[9]  = '{4'b1010, 4'b0010, 5'd9};
        tbl[10] = '{4'b1011, 4'b1000, 5'd10};
        tbl[11] = '{4'b0101, 4'b0001, 5'd11};
        tbl[12] = '{4'b0101, 4'b0100, 5'd12};
        tbl[13] = '{4'b0110, 4'b0010, 5'd13};

        rst = 1'b1; arm = 1'b0; stop = 1'b0; continuous = 1'b0; trig_in = 1'b0;
        trig_match_en = 1'b0; post_cnt = '0; trig_type_mask = '0; trig_src_mask = '0;
        bus.ch_valid = '1; bus.rd_en = 1'b0; bus.rd_addr = '0;
        set_all(c_ev_idle, 32'd0);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",    ENTRY_W'(state),        ENTRY_W'(ST_IDLE));
        chk("rst_count",    ENTRY_W'(count),        '0);
        chk("rst_trigpos",  ENTRY_W'(trigger_pos),  '0);
        chk("rst_wrapped",  ENTRY_W'(wrapped),      '0);
        chk("rst_trig",     ENTRY_W'(triggered),    '0);
        chk("rst_rdvalid",  ENTRY_W'(bus.rd_valid), '0);
        chk("rst_rddata",   bus.rd_data,            '0);
        chk("rst_ready",    ENTRY_W'(bus.ch_ready), '0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_ready", ENTRY_W'(bus.ch_ready), '0);

        // Round-robin table
        do_arm();
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            bus.ch_valid = tbl[v].valid;
            set_all(c_ev_fdc_cmd, 32'(v));
            #1;
            chk($sformatf("rr_ready_%0d", v), ENTRY_W'(bus.ch_ready), ENTRY_W'(tbl[v].ready));
            if (tbl[v].ready != '0)
                exp_q.push_back(ent(TS_W'(v), oh2idx(tbl[v].ready),
                                    pl(c_ev_fdc_cmd, 8'(oh2idx(tbl[v].ready)), 32'(v))));
            @(posedge clk);
            #1 chk($sformatf("rr_count_%0d", v), ENTRY_W'(count), ENTRY_W'(tbl[v].cnt));
        end
        @(negedge clk);
        bus.ch_valid = '0;
        chk("rr_state", ENTRY_W'(state), ENTRY_W'(ST_PRE));
        for (int i = 0; i < exp_q.size(); i++)
            rd_chk($sformatf("rr_rd_%0d", i), DEPTH_LOG2'(i), exp_q[i]);

        // Wrap, trig_in at entry 12, post_cnt 3
        post_cnt = 4'd3;
        do_arm();
        bus.ch_valid = '1;
        for (int v = 0; v < 20; v++) begin
            @(negedge clk);
            set_all(c_ev_hdd_cmd, 32'(v));
            trig_in = (v == 12);
            if (v == 16) #1 chk("t2_ready_done", ENTRY_W'(bus.ch_ready), '0);
            @(posedge clk);
            #1;
            if (v == 12) chk("t2_state_post12", ENTRY_W'(state), ENTRY_W'(ST_POST));
            if (v == 14) chk("t2_state_post14", ENTRY_W'(state), ENTRY_W'(ST_POST));
            if (v == 15) chk("t2_state_done",   ENTRY_W'(state), ENTRY_W'(ST_DONE));
        end
        @(negedge clk);
        trig_in = 1'b0;
        bus.ch_valid = '0;
        chk("t2_count",   ENTRY_W'(count),       ENTRY_W'(16));
        chk("t2_wrapped", ENTRY_W'(wrapped),     ENTRY_W'(1));
        chk("t2_trigpos", ENTRY_W'(trigger_pos), ENTRY_W'(12));
        chk("t2_trig",    ENTRY_W'(triggered),   ENTRY_W'(1));
        rd_chk("t2_rd0",  4'd0,  ent(16'd0,  2'd0, pl(c_ev_hdd_cmd, 8'd0, 32'd0)));
        rd_chk("t2_rd12", 4'd12, ent(16'd12, 2'd0, pl(c_ev_hdd_cmd, 8'd0, 32'd12)));
        rd_chk("t2_rd15", 4'd15, ent(16'd15, 2'd3, pl(c_ev_hdd_cmd, 8'd3, 32'd15)));

        // Event-match trigger: type 0x05 src 0x01 misses the source mask
        post_cnt = 4'd5;
        trig_match_en = 1'b1; trig_type_mask = 8'h04; trig_src_mask = 8'h02;
        do_arm();
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            bus.ch_valid = 4'b0001;
            bus.ch_data[0 +: PAYLOAD_W] = pl(c_ev_usb_xfer, c_src_fdc, 32'(v));
            @(posedge clk);
            #1 chk($sformatf("t3_notrig_%0d", v), ENTRY_W'(triggered), '0);
        end
        @(negedge clk);
        bus.ch_valid = 4'b0100;
        bus.ch_data[2*PAYLOAD_W +: PAYLOAD_W] = pl(c_ev_usb_xfer, c_src_usb, 32'hABCD);
        #1 chk("t3_ready", ENTRY_W'(bus.ch_ready), ENTRY_W'(4'b0100));
        @(posedge clk);
        #1;
        chk("t3_trig",    ENTRY_W'(triggered),   ENTRY_W'(1));
        chk("t3_state",   ENTRY_W'(state),       ENTRY_W'(ST_POST));
        chk("t3_trigpos", ENTRY_W'(trigger_pos), ENTRY_W'(2));
        @(negedge clk);
        bus.ch_valid = '0;
        trig_match_en = 1'b0;
        rd_chk("t3_rd2", 4'd2, ent(16'd2, 2'd2, pl(c_ev_usb_xfer, c_src_usb, 32'hABCD)));

        // post_cnt 0 with a write-coincident trigger
        post_cnt = 4'd0;
        do_arm();
        @(negedge clk);
        bus.ch_valid = 4'b0001;
        set_all(c_ev_pll_lock, 32'd7);
        @(posedge clk);
        #1 chk("t4_state_pre", ENTRY_W'(state), ENTRY_W'(ST_PRE));
        @(negedge clk);
        bus.ch_valid = 4'b0010;
        trig_in = 1'b1;
        #1 chk("t4_ready", ENTRY_W'(bus.ch_ready), ENTRY_W'(4'b0010));
        @(posedge clk);
        #1;
        chk("t4_state_done", ENTRY_W'(state),       ENTRY_W'(ST_DONE));
        chk("t4_trigpos",    ENTRY_W'(trigger_pos), ENTRY_W'(1));
        @(negedge clk);
        trig_in = 1'b0;
        bus.ch_valid = '1;
        #1 chk("t4_ready_done", ENTRY_W'(bus.ch_ready), '0);
        @(posedge clk);
        #1 chk("t4_count", ENTRY_W'(count), ENTRY_W'(2));

        // Continuous mode, stop, re-arm, arm beats stop
        post_cnt = 4'd3;
        continuous = 1'b1;
        do_arm();
        @(negedge clk);
        trig_in = 1'b1;
        @(posedge clk);
        #1 chk("t5_state_post", ENTRY_W'(state), ENTRY_W'(ST_POST));
        @(negedge clk);
        trig_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t5_state_cont", ENTRY_W'(state),   ENTRY_W'(ST_POST));
        chk("t5_count",      ENTRY_W'(count),   ENTRY_W'(16));
        chk("t5_wrapped",    ENTRY_W'(wrapped), ENTRY_W'(1));
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1 chk("t5_stop_done", ENTRY_W'(state), ENTRY_W'(ST_DONE));
        @(negedge clk);
        stop = 1'b0;
        bus.ch_valid = '0;
        do_arm();
        chk("t5_arm_state", ENTRY_W'(state),   ENTRY_W'(ST_PRE));
        chk("t5_arm_count", ENTRY_W'(count),   '0);
        chk("t5_arm_wrap",  ENTRY_W'(wrapped), '0);
        @(negedge clk);
        bus.ch_valid = 4'b1000;
        set_all(c_ev_marker, 32'h55);
        #1 chk("t5_ready3", ENTRY_W'(bus.ch_ready), ENTRY_W'(4'b1000));
        @(posedge clk);
        #1 chk("t5_count1", ENTRY_W'(count), ENTRY_W'(1));
        @(negedge clk);
        bus.ch_valid = '0;
        arm = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1 chk("t5_arm_wins", ENTRY_W'(state), ENTRY_W'(ST_PRE));
        arm = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        rd_chk("t5_rd0", 4'd0, ent(16'd0, 2'd3, pl(c_ev_marker, 8'd3, 32'h55)));

        // Reset in POST with a read in flight
        post_cnt = 4'd5;
        do_arm();
        bus.ch_valid = '1;
        @(negedge clk);
        trig_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trig_in = 1'b0;
        bus.rd_en = 1'b1;
        bus.rd_addr = '0;
        @(posedge clk);
        #1;
        chk("t6_state_post", ENTRY_W'(state),        ENTRY_W'(ST_POST));
        chk("t6_rdvalid_on", ENTRY_W'(bus.rd_valid), ENTRY_W'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_state", ENTRY_W'(state),        ENTRY_W'(ST_IDLE));
        chk("t6_count", ENTRY_W'(count),        '0);
        chk("t6_rdval", ENTRY_W'(bus.rd_valid), '0);
        chk("t6_ready", ENTRY_W'(bus.ch_ready), '0);
        chk("t6_trig",  ENTRY_W'(triggered),    '0);
        @(negedge clk);
        rst = 1'b0;
        bus.rd_en = 1'b0;
        bus.ch_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
